// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with multi-beat frame accumulation for SNN membrane updates.
// Define ADDER_TREE_SAT_EN to clamp the frame sum; otherwise the legacy sign+low-bits packing is used.
module pipelined_adder_tree #(
    parameter int N          = 2,
    parameter int NUM_INPUTS = 256,
    parameter int REG_EVERY  = 1,
    parameter int ACC_BITS   = 4,
    parameter int OUT_WIDTH  = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N*NUM_INPUTS-1:0] inputs_i,
    input  logic                    valid_i,
    input  logic                    first_i,
    input  logic                    last_i,
    output logic [OUT_WIDTH-1:0]    sum_o,
    output logic                    valid_o,
    output logic                    overflow_o,
    output logic                    busy_o
);

    localparam int STAGES = $clog2(NUM_INPUTS);
    localparam int TW     = N + STAGES;
    localparam int ACC_W  = TW + ACC_BITS;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [ACC_BITS:0] CNT_LIMIT = {1'b1, {ACC_BITS{1'b0}}};

    logic [STAGES-1:0] pipe_vld;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int  CNT    = NUM_INPUTS >> (s + 1);
        localparam int  W      = N + s + 1;
        localparam bit  IS_REG = (((s + 1) % REG_EVERY) == 0) || (s == STAGES - 1);

        logic signed [W-2:0] in_val [2*CNT];
        logic                in_vld, in_fst, in_lst;
        logic signed [W-1:0] sum_d  [CNT];
        logic signed [W-1:0] out_val [CNT];
        logic                out_vld, out_fst, out_lst;

        if (s == 0) begin : g_src
            for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_elem
                assign in_val[k] = inputs_i[k*N +: N];
            end
            assign in_vld = valid_i;
            assign in_fst = first_i & valid_i;
            assign in_lst = last_i & valid_i;
        end else begin : g_chain
            for (genvar k = 0; k < 2*CNT; k++) begin : g_elem
                assign in_val[k] = g_stage[s-1].out_val[k];
            end
            assign in_vld = g_stage[s-1].out_vld;
            assign in_fst = g_stage[s-1].out_fst;
            assign in_lst = g_stage[s-1].out_lst;
        end

        // Operands are sign-extended one bit per level, so the tree never wraps.
        always_comb begin
            for (int i = 0; i < CNT; i++) begin
                sum_d[i] = W'(in_val[2*i]) + W'(in_val[2*i+1]);
            end
        end

        if (IS_REG) begin : g_reg
            logic signed [W-1:0] val_q [CNT];
            logic                vld_q, fst_q, lst_q;

            always_ff @(posedge clk_i) begin
                val_q <= sum_d;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_q <= 1'b0;
                    fst_q <= 1'b0;
                    lst_q <= 1'b0;
                end else begin
                    vld_q <= in_vld;
                    fst_q <= in_fst;
                    lst_q <= in_lst;
                end
            end

            assign out_val     = val_q;
            assign out_vld     = vld_q;
            assign out_fst     = fst_q;
            assign out_lst     = lst_q;
            assign pipe_vld[s] = vld_q;
        end else begin : g_comb
            assign out_val     = sum_d;
            assign out_vld     = in_vld;
            assign out_fst     = in_fst;
            assign out_lst     = in_lst;
            assign pipe_vld[s] = 1'b0;
        end
    end

    logic signed [TW-1:0] tree_sum;
    logic                 tree_vld, tree_fst, tree_lst;

    assign tree_sum = g_stage[STAGES-1].out_val[0];
    assign tree_vld = g_stage[STAGES-1].out_vld;
    assign tree_fst = g_stage[STAGES-1].out_fst;
    assign tree_lst = g_stage[STAGES-1].out_lst;

    logic signed [ACC_W-1:0]     acc_q, acc_d, acc_next;
    logic [ACC_BITS:0]           cnt_q, cnt_d, cnt_next;
    logic                        open_q, open_d;
    logic [OUT_WIDTH-1:0]        out_sum_q, out_sum_d, reduced;
    logic                        out_vld_q, out_vld_d;
    logic                        ovf_q, ovf_d;
    logic                        range_ovf, cnt_ovf;

    always_comb begin
        acc_next  = tree_fst ? ACC_W'(tree_sum) : acc_q + ACC_W'(tree_sum);
        cnt_next  = tree_fst ? (ACC_BITS+1)'(1)
                  : ((cnt_q == '1) ? cnt_q : cnt_q + (ACC_BITS+1)'(1));
        range_ovf = (acc_next > SAT_MAX) || (acc_next < SAT_MIN);
        cnt_ovf   = cnt_next > CNT_LIMIT;
`ifdef ADDER_TREE_SAT_EN
        if (acc_next > SAT_MAX) begin
            reduced = SAT_MAX[OUT_WIDTH-1:0];
        end else if (acc_next < SAT_MIN) begin
            reduced = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            reduced = acc_next[OUT_WIDTH-1:0];
        end
`else
        reduced = {acc_next[ACC_W-1], acc_next[OUT_WIDTH-2:0]};
`endif
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        open_d    = open_q;
        out_sum_d = out_sum_q;
        ovf_d     = ovf_q;
        out_vld_d = 1'b0;
        // A closing beat publishes the frame and leaves acc/cnt cleared for the next one.
        if (tree_vld) begin
            if (tree_lst) begin
                acc_d     = '0;
                cnt_d     = '0;
                open_d    = 1'b0;
                out_sum_d = reduced;
                ovf_d     = range_ovf | cnt_ovf;
                out_vld_d = 1'b1;
            end else begin
                acc_d  = acc_next;
                cnt_d  = cnt_next;
                open_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            open_q    <= 1'b0;
            out_sum_q <= '0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            open_q    <= open_d;
            out_sum_q <= out_sum_d;
            out_vld_q <= out_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign sum_o      = out_sum_q;
    assign valid_o    = out_vld_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (|pipe_vld) | open_q | out_vld_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed self-checking bench for pipelined_adder_tree at default parameters.
// Expected sums follow the ADDER_TREE_SAT_EN setting of the build.
module tb_pipelined_adder_tree;

    localparam int N   = 2;
    localparam int NI  = 256;
    localparam int OW  = 9;
    localparam int LAT = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*NI-1:0] inputs;
    logic          valid, first, last;
    logic [OW-1:0] sum;
    logic          valid_o, ovf, busy;

    int vectors     = 0;
    int miscompares = 0;

    pipelined_adder_tree dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .inputs_i   (inputs),
        .valid_i    (valid),
        .first_i    (first),
        .last_i     (last),
        .sum_o      (sum),
        .valid_o    (valid_o),
        .overflow_o (ovf),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N*NI-1:0] make_vec(input int count, input logic [1:0] val);
        logic [N*NI-1:0] v;
        v = '0;
        for (int k = 0; k < count; k++) v[k*N +: N] = val;
        return v;
    endfunction

    task automatic idle();
        valid  = 1'b0;
        first  = 1'b0;
        last   = 1'b0;
        inputs = '0;
    endtask

    task automatic drive(input int count, input logic [1:0] val, input logic f, input logic l);
        inputs = make_vec(count, val);
        valid  = 1'b1;
        first  = f;
        last   = l;
    endtask

    // Drives one beat for one clock edge, returning at the following negedge.
    task automatic apply_beat(input int count, input logic [1:0] val, input logic f, input logic l);
        drive(count, val, f, l);
        @(negedge clk);
        idle();
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (valid_o) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        vectors++;
        if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
        vectors++;
        if (sum !== 9'h000) begin miscompares++; $display("[TB] FAIL reset_sum: got %h expected 000", sum); end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_busy();
        int edges;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_idle: got %b expected 0", busy); end
        apply_beat(3, 2'b01, 1'b1, 1'b1);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_inflight: got %b expected 1", busy); end
        wait_valid(LAT + 4, edges);
        vectors++;
        if (edges !== LAT - 1) begin miscompares++; $display("[TB] FAIL busy_latency: got %0d expected %0d", edges, LAT - 1); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_at_valid: got %b expected 1", busy); end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_all_pos();
        int edges;
        logic [OW-1:0] exp_sum;
`ifdef ADDER_TREE_SAT_EN
        exp_sum = 9'd255;
`else
        exp_sum = 9'd0;
`endif
        apply_beat(NI, 2'b01, 1'b1, 1'b1);
        wait_valid(LAT + 4, edges);
        vectors++;
        if (edges !== LAT - 1) begin miscompares++; $display("[TB] FAIL pos_latency: got %0d expected %0d", edges, LAT - 1); end
        vectors++;
        if (sum !== exp_sum) begin miscompares++; $display("[TB] FAIL pos_sum: got %0d expected %0d", sum, exp_sum); end
        vectors++;
        if (ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL pos_ovf: got %b expected 1", ovf); end
        @(negedge clk);
    endtask

    task automatic test_all_neg();
        int edges;
        apply_beat(NI, 2'b11, 1'b1, 1'b1);
        wait_valid(LAT + 4, edges);
        vectors++;
        if (edges !== LAT - 1) begin miscompares++; $display("[TB] FAIL neg_latency: got %0d expected %0d", edges, LAT - 1); end
        vectors++;
        if (sum !== 9'h100) begin miscompares++; $display("[TB] FAIL neg_sum: got %h expected 100", sum); end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL neg_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL neg_pulse: got %b expected 0", valid_o); end
        vectors++;
        if (sum !== 9'h100) begin miscompares++; $display("[TB] FAIL neg_hold: got %h expected 100", sum); end
    endtask

    task automatic test_multi_beat();
        int pulses = 0;
        int first_k = -1;
        logic [OW-1:0] got_sum = '0;
        logic got_ovf = 1'b0;
        apply_beat(64, 2'b01, 1'b1, 1'b0);
        @(negedge clk);
        apply_beat(100, 2'b11, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        apply_beat(10, 2'b10, 1'b0, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (valid_o) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k;
                    got_sum = sum;
                    got_ovf = ovf;
                end
            end
        end
        vectors++;
        if (pulses !== 1) begin miscompares++; $display("[TB] FAIL multi_pulses: got %0d expected 1", pulses); end
        vectors++;
        if (first_k !== LAT - 1) begin miscompares++; $display("[TB] FAIL multi_latency: got %0d expected %0d", first_k, LAT - 1); end
        vectors++;
        if (got_sum !== 9'h1C8) begin miscompares++; $display("[TB] FAIL multi_sum: got %h expected 1c8", got_sum); end
        vectors++;
        if (got_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL multi_ovf: got %b expected 0", got_ovf); end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        for (int t = 0; t < 36; t++) begin
            if (t < 20) drive(t + 1, 2'b01, 1'b1, 1'b1);
            else idle();
            @(negedge clk);
            if (valid_o) begin
                vectors++;
                if (t !== LAT - 1 + seen) begin miscompares++; $display("[TB] FAIL b2b_slot: got %0d expected %0d", t, LAT - 1 + seen); end
                vectors++;
                if (sum !== OW'(seen + 1)) begin miscompares++; $display("[TB] FAIL b2b_sum: got %0d expected %0d", sum, seen + 1); end
                seen++;
            end
        end
        vectors++;
        if (seen !== 20) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected 20", seen); end
    endtask

    task automatic test_reset_mid();
        int edges;
        apply_beat(128, 2'b01, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_busy_pre: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        vectors++;
        if (sum !== 9'h000) begin miscompares++; $display("[TB] FAIL mid_sum: got %h expected 000", sum); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        vectors++;
        if ({valid_o, ovf} !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_flags: got %b expected 00", {valid_o, ovf}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        apply_beat(5, 2'b01, 1'b1, 1'b1);
        wait_valid(LAT + 4, edges);
        vectors++;
        if (edges !== LAT - 1) begin miscompares++; $display("[TB] FAIL mid_latency: got %0d expected %0d", edges, LAT - 1); end
        vectors++;
        if (sum !== 9'd5) begin miscompares++; $display("[TB] FAIL mid_after_sum: got %0d expected 5", sum); end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_after_ovf: got %b expected 0", ovf); end
        @(negedge clk);
    endtask

    task automatic test_count_overflow();
        int edges;
        for (int b = 1; b <= 17; b++) begin
            apply_beat(1, 2'b01, b == 1, b == 17);
        end
        wait_valid(LAT + 4, edges);
        vectors++;
        if (edges !== LAT - 1) begin miscompares++; $display("[TB] FAIL cnt_latency: got %0d expected %0d", edges, LAT - 1); end
        vectors++;
        if (ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL cnt_ovf: got %b expected 1", ovf); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_busy();
        test_all_pos();
        test_all_neg();
        test_multi_beat();
        test_back_to_back();
        test_reset_mid();
        test_count_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
